// File: rtl/ram_input_loader.sv
// rtl/ram_input_loader.sv - raster pixel stream to banked input feature-map RAM write port
module ram_input_loader #(
    parameter int NUM_BANKS = 13,
    parameter int NUM_ROWS  = 19,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_last,
    input  logic [DATA_W-1:0]    s_data_c0,
    input  logic [DATA_W-1:0]    s_data_c1,
    input  logic [DATA_W-1:0]    s_data_c2,
    output logic [ADDR_W-1:0]    addr_write,
    output logic [NUM_BANKS-1:0] write_enable,
    output logic [DATA_W-1:0]    wdata_c0,
    output logic [DATA_W-1:0]    wdata_c1,
    output logic [DATA_W-1:0]    wdata_c2,
    output logic                 busy,
    output logic                 load_done,
    output logic                 frame_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        col;
    logic [ADDR_W-1:0] row;

    logic accept;
    logic last_pix;

    assign s_ready  = (state == LOAD);
    assign accept   = s_valid && s_ready;
    assign last_pix = (col == 4'(NUM_BANKS - 1)) && (row == ADDR_W'(NUM_ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            addr_write   <= '0;
            write_enable <= '0;
            wdata_c0     <= '0;
            wdata_c1     <= '0;
            wdata_c2     <= '0;
            busy         <= 1'b0;
            load_done    <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            write_enable <= '0;
            load_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        col       <= '0;
                        row       <= '0;
                        busy      <= 1'b1;
                        frame_err <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        write_enable <= NUM_BANKS'(1) << col;
                        addr_write   <= row;
                        wdata_c0     <= s_data_c0;
                        wdata_c1     <= s_data_c1;
                        wdata_c2     <= s_data_c2;
                        // Frame ends on the last pixel or an early s_last; a mismatch between the two is a framing error.
                        if (last_pix || s_last) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            if (last_pix != s_last) begin
                                frame_err <= 1'b1;
                            end
                        end else if (col == 4'(NUM_BANKS - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
